// File: rtl/vec_packet_pkg.sv
// Shared types and widths for the vectored packet serializer/deserializer pair.
package vec_packet_pkg;

  localparam int NUM_SLOTS = 3;
  localparam int HEADER_W  = 16;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int CNT_W     = 16;
  localparam int SLOT_W    = 2;

  typedef struct packed {
    logic [HEADER_W-1:0] header;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
  } packet_t;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  // Binary index of a one-hot slot vector; all-zero input maps to slot 0.
  function automatic logic [SLOT_W-1:0] oneHotToIndex(input logic [NUM_SLOTS-1:0] oneHot);
    logic [SLOT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (oneHot[i]) idx = SLOT_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vec_slot_picker.sv
// Lowest-set-bit picker over a slot mask: one-hot pick, binary index,
// any-set flag and a flag for exactly one bit remaining.
module vec_slot_picker
  import vec_packet_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] remMask,
  output logic [NUM_SLOTS-1:0] pick,
  output logic [SLOT_W-1:0]    index,
  output logic                 any,
  output logic                 last
);

  // Isolate the lowest set bit and derive index / population flags.
  always_comb begin
    // NOTE: every output gets a value on every path through this block, so no latch is inferred.
    pick  = remMask & (~remMask + NUM_SLOTS'(1));
    index = oneHotToIndex(pick);
    any   = |remMask;
    last  = any && ((remMask & (remMask - NUM_SLOTS'(1))) == '0);
  end

endmodule

// File: rtl/vec_packet_serializer.sv
// Serializes one 3-slot packet vector into single-packet beats, lowest
// selected slot first, with a wrapping count of beats handed downstream.
module vec_packet_serializer
  import vec_packet_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                io_inPacket_valid,
  output logic                io_inPacket_ready,
  input  logic [NUM_SLOTS-1:0] io_inPacket_mask,
  input  logic [HEADER_W-1:0] io_inPacket_tx_header_0,
  input  logic [HEADER_W-1:0] io_inPacket_tx_header_1,
  input  logic [HEADER_W-1:0] io_inPacket_tx_header_2,
  input  logic [ADDR_W-1:0]   io_inPacket_tx_addr_0,
  input  logic [ADDR_W-1:0]   io_inPacket_tx_addr_1,
  input  logic [ADDR_W-1:0]   io_inPacket_tx_addr_2,
  input  logic [DATA_W-1:0]   io_inPacket_tx_data_0,
  input  logic [DATA_W-1:0]   io_inPacket_tx_data_1,
  input  logic [DATA_W-1:0]   io_inPacket_tx_data_2,
  output logic                io_outPacket_valid,
  input  logic                io_outPacket_ready,
  output logic [HEADER_W-1:0] io_outPacket_header,
  output logic [ADDR_W-1:0]   io_outPacket_addr,
  output logic [DATA_W-1:0]   io_outPacket_data,
  output logic [SLOT_W-1:0]   io_outPacket_slot,
  output logic                io_outPacket_last,
  output logic [CNT_W-1:0]    io_sentCount
);

  state_t               state;
  state_t               nextState;
  logic                 inReadyReg;
  logic [NUM_SLOTS-1:0] remMask;
  packet_t              holdPkt [NUM_SLOTS];
  packet_t              inPkt   [NUM_SLOTS];
  packet_t              selPkt;
  logic [CNT_W-1:0]     sentCount;

  logic [NUM_SLOTS-1:0] pick;
  logic [SLOT_W-1:0]    pickIndex;
  logic                 pickAny;
  logic                 pickLast;
  logic                 inFire;
  logic                 outFire;

  assign inPkt[0] = {io_inPacket_tx_header_0, io_inPacket_tx_addr_0, io_inPacket_tx_data_0};
  assign inPkt[1] = {io_inPacket_tx_header_1, io_inPacket_tx_addr_1, io_inPacket_tx_data_1};
  assign inPkt[2] = {io_inPacket_tx_header_2, io_inPacket_tx_addr_2, io_inPacket_tx_data_2};

  // A vector is taken only from IDLE with the registered ready high; a beat
  // leaves whenever SEND (valid) meets downstream ready.
  assign inFire  = (state == IDLE) && io_inPacket_valid && inReadyReg;
  assign outFire = (state == SEND) && io_outPacket_ready;

  vec_slot_picker u_picker (
    .remMask (remMask),
    .pick    (pick),
    .index   (pickIndex),
    .any     (pickAny),
    .last    (pickLast)
  );

  // State register plus registered input ready, so downstream ready never
  // reaches upstream ready combinationally.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: state elements are written with non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state      <= IDLE;
      inReadyReg <= 1'b0;
    end else begin
      state      <= nextState;
      inReadyReg <= (nextState == IDLE);
    end
  end

  // Next-state decode: a non-empty vector starts SEND, the last beat ends it.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (inFire && (io_inPacket_mask != '0)) nextState = SEND;
      SEND: if (!pickAny || (outFire && pickLast)) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Holding registers, remaining mask and beat counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the three holding slots are reset as well; they are few and it keeps the outputs at zero out of reset.
      for (int i = 0; i < NUM_SLOTS; i++) holdPkt[i] <= '0;
      remMask   <= '0;
      sentCount <= '0;
    end else begin
      if (inFire) begin
        for (int i = 0; i < NUM_SLOTS; i++) holdPkt[i] <= inPkt[i];
        remMask <= io_inPacket_mask;
      end else if (outFire) begin
        remMask   <= remMask & ~pick;
        sentCount <= sentCount + CNT_W'(1);
      end
    end
  end

  // Output decode: beat fields come from the picked holding slot while in SEND.
  always_comb begin
    selPkt = '0;
    if (state == SEND) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (pick[i]) selPkt = holdPkt[i];
      end
    end
    io_outPacket_valid  = (state == SEND);
    io_outPacket_header = selPkt.header;
    io_outPacket_addr   = selPkt.addr;
    io_outPacket_data   = selPkt.data;
    io_outPacket_slot   = (state == SEND) ? pickIndex : '0;
    io_outPacket_last   = (state == SEND) && pickLast;
  end

  assign io_inPacket_ready = inReadyReg;
  assign io_sentCount      = sentCount;

endmodule

// File: tb/tb_vec_packet_serializer.sv
// Directed bench for vec_packet_serializer: inputs driven and outputs
// sampled on the falling clock edge, expectations written by hand.
module tb_vec_packet_serializer;

  logic        clock;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [2:0]  inMask;
  logic [15:0] hdr  [3];
  logic [15:0] addr [3];
  logic [31:0] data [3];
  logic        outValid;
  logic        outReady;
  logic [15:0] outHeader;
  logic [15:0] outAddr;
  logic [31:0] outData;
  logic [1:0]  outSlot;
  logic        outLast;
  logic [15:0] sentCount;

  int errors = 0;
  int checks = 0;

  vec_packet_serializer dut (
    .clock                   (clock),
    .reset                   (reset),
    .io_inPacket_valid       (inValid),
    .io_inPacket_ready       (inReady),
    .io_inPacket_mask        (inMask),
    .io_inPacket_tx_header_0 (hdr[0]),
    .io_inPacket_tx_header_1 (hdr[1]),
    .io_inPacket_tx_header_2 (hdr[2]),
    .io_inPacket_tx_addr_0   (addr[0]),
    .io_inPacket_tx_addr_1   (addr[1]),
    .io_inPacket_tx_addr_2   (addr[2]),
    .io_inPacket_tx_data_0   (data[0]),
    .io_inPacket_tx_data_1   (data[1]),
    .io_inPacket_tx_data_2   (data[2]),
    .io_outPacket_valid      (outValid),
    .io_outPacket_ready      (outReady),
    .io_outPacket_header     (outHeader),
    .io_outPacket_addr       (outAddr),
    .io_outPacket_data       (outData),
    .io_outPacket_slot       (outSlot),
    .io_outPacket_last       (outLast),
    .io_sentCount            (sentCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBeat(input string tag, input logic [1:0] slot, input logic [15:0] h,
                           input logic [15:0] a, input logic [31:0] d, input logic lst);
    check($sformatf("%s_valid", tag),  outValid,  1);
    check($sformatf("%s_slot", tag),   outSlot,   slot);
    check($sformatf("%s_header", tag), outHeader, h);
    check($sformatf("%s_addr", tag),   outAddr,   a);
    check($sformatf("%s_data", tag),   outData,   d);
    check($sformatf("%s_last", tag),   outLast,   lst);
  endtask

  task automatic loadVec(input logic [2:0] m, input logic [15:0] hBase, input logic [15:0] aBase,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    inMask = m;
    for (int i = 0; i < 3; i++) begin
      hdr[i]  = hBase + 16'(i);
      addr[i] = aBase + 16'(i);
    end
    data[0] = d0;
    data[1] = d1;
    data[2] = d2;
  endtask

  // Offer the loaded vector until accepted (bounded), return on the negedge after acceptance.
  task automatic sendVec(output bit ok);
    int budget;
    budget  = 0;
    inValid = 1'b1;
    while (!inReady && budget < 20) begin
      @(negedge clock);
      budget++;
    end
    ok = inReady;
    @(negedge clock);
    inValid = 1'b0;
  endtask

  initial begin
    bit ok;
    bit allOk;

    reset    = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    loadVec(3'b000, 16'h0, 16'h0, 32'h0, 32'h0, 32'h0);

    // Reset state
    #2 reset = 1'b0;
    #1;
    check("rst_in_ready",  inReady,   0);
    check("rst_out_valid", outValid,  0);
    check("rst_count",     sentCount, 0);
    check("rst_header",    outHeader, 0);
    check("rst_slot",      outSlot,   0);
    check("rst_last",      outLast,   0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1 check("ready_before_first_edge", inReady, 0);
    @(negedge clock);
    check("ready_after_first_edge", inReady, 1);

    // Full vector, downstream always ready
    outReady = 1'b1;
    loadVec(3'b111, 16'hA000, 16'h1000, 32'h11111111, 32'h22222222, 32'h33333333);
    inValid = 1'b1;
    @(negedge clock);
    inValid = 1'b0;
    check("full_in_ready_low", inReady, 0);
    checkBeat("full_b0", 2'd0, 16'hA000, 16'h1000, 32'h11111111, 1'b0);
    @(negedge clock);
    checkBeat("full_b1", 2'd1, 16'hA001, 16'h1001, 32'h22222222, 1'b0);
    @(negedge clock);
    checkBeat("full_b2", 2'd2, 16'hA002, 16'h1002, 32'h33333333, 1'b1);
    @(negedge clock);
    check("full_done_valid", outValid,  0);
    check("full_done_count", sentCount, 3);
    check("full_done_ready", inReady,   1);

    // Sparse mask: slots 0 and 2 only
    loadVec(3'b101, 16'hB000, 16'h2000, 32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002);
    inValid = 1'b1;
    @(negedge clock);
    inValid = 1'b0;
    checkBeat("sparse_b0", 2'd0, 16'hB000, 16'h2000, 32'hDEAD0000, 1'b0);
    @(negedge clock);
    checkBeat("sparse_b1", 2'd2, 16'hB002, 16'h2002, 32'hDEAD0002, 1'b1);
    @(negedge clock);
    check("sparse_done_valid", outValid,  0);
    check("sparse_done_count", sentCount, 5);
    check("sparse_done_ready", inReady,   1);

    // Backpressure: five stalled cycles, input scribbled meanwhile
    outReady = 1'b0;
    loadVec(3'b011, 16'hC000, 16'h3000, 32'hCAFE0000, 32'hCAFE0001, 32'hCAFE0002);
    inValid = 1'b1;
    @(negedge clock);
    inValid = 1'b0;
    loadVec(3'b111, 16'hFFF0, 16'hFFF0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int c = 0; c < 5; c++) begin
      checkBeat($sformatf("bp_stall%0d", c), 2'd0, 16'hC000, 16'h3000, 32'hCAFE0000, 1'b0);
      check($sformatf("bp_stall%0d_count", c), sentCount, 5);
      check($sformatf("bp_stall%0d_in_ready", c), inReady, 0);
      if (c < 4) @(negedge clock);
    end
    outReady = 1'b1;
    @(negedge clock);
    checkBeat("bp_b1", 2'd1, 16'hC001, 16'h3001, 32'hCAFE0001, 1'b1);
    @(negedge clock);
    check("bp_done_valid", outValid,  0);
    check("bp_done_count", sentCount, 7);

    // Empty mask: consumed, nothing emitted
    check("empty_pre_ready", inReady, 1);
    inMask  = 3'b000;
    inValid = 1'b1;
    @(negedge clock);
    inValid = 1'b0;
    check("empty_valid0", outValid,  0);
    check("empty_ready0", inReady,   1);
    check("empty_count0", sentCount, 7);
    @(negedge clock);
    check("empty_valid1", outValid,  0);
    check("empty_count1", sentCount, 7);

    // Reset asserted mid-stream
    loadVec(3'b111, 16'hD000, 16'h4000, 32'h0D0D0000, 32'h0D0D0001, 32'h0D0D0002);
    inValid = 1'b1;
    @(negedge clock);
    inValid = 1'b0;
    checkBeat("mid_b0", 2'd0, 16'hD000, 16'h4000, 32'h0D0D0000, 1'b0);
    @(negedge clock);
    checkBeat("mid_b1", 2'd1, 16'hD001, 16'h4001, 32'h0D0D0001, 1'b0);
    check("mid_count_before", sentCount, 8);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", outValid,  0);
    check("mid_rst_count", sentCount, 0);
    check("mid_rst_ready", inReady,   0);
    @(negedge clock);
    check("mid_rst_hold_valid", outValid, 0);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rel_ready", inReady,   1);
    check("mid_rel_valid", outValid,  0);
    @(negedge clock);
    check("mid_rel_valid2", outValid,  0);
    check("mid_rel_count",  sentCount, 0);

    // Counter wrap: 21845 full vectors = 65535 beats, then one more beat
    outReady = 1'b1;
    loadVec(3'b111, 16'h5000, 16'h5000, 32'h5, 32'h6, 32'h7);
    allOk = 1'b1;
    for (int v = 0; v < 21845; v++) begin
      sendVec(ok);
      if (!ok) allOk = 1'b0;
    end
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    check("wrap_all_accepted", allOk,     1);
    check("wrap_count_max",    sentCount, 16'hFFFF);
    check("wrap_idle_valid",   outValid,  0);
    loadVec(3'b100, 16'hE000, 16'h6000, 32'hE0, 32'hE1, 32'hE2);
    sendVec(ok);
    check("wrap_single_accepted", ok, 1);
    checkBeat("wrap_b", 2'd2, 16'hE002, 16'h6002, 32'hE2, 1'b1);
    @(negedge clock);
    check("wrap_count_zero", sentCount, 16'h0000);
    check("wrap_done_valid", outValid,  0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
